sigma_delta_adc: RTL and testbench

Receive-side companion to the board's sigma-delta PWM DAC. It samples a 1-bit modulator stream from an external comparator on a prescaled tick, drives the comparator's RC feedback pin, and decimates the stream into a DAC_WIDTH-bit code. Decimation is a boxcar count of ones over a fixed window. Results are published with a one-clock valid strobe to the processing-unit register file, which reads analog monitor inputs (supply and backlight sense) through this block.

---
 rtl/sigma_delta_adc.sv | 126 ++++++++++++
 tb/tb_sigma_delta_adc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_adc.sv
// sigma_delta_adc: samples a 1-bit comparator stream on a prescaled tick, drives
// the RC feedback pin, and decimates the stream into a DAC_WIDTH-bit code using
// a boxcar count of ones over a 2^DAC_WIDTH-tick window.
module sigma_delta_adc #(
    parameter int unsigned CLOCK_PRESCALER = 24,
    parameter int unsigned DAC_WIDTH       = 12,
    parameter int unsigned SETTLE_WINDOWS  = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sdm_in,
    output logic                 sdm_fb,
    output logic [DAC_WIDTH-1:0] adc_value,
    output logic                 adc_valid,
    output logic                 adc_overrange
);

    localparam int unsigned PwRaw = $clog2(CLOCK_PRESCALER + 1);
    localparam int unsigned PW    = (PwRaw > 0) ? PwRaw : 1;
    localparam int unsigned SwRaw = $clog2(SETTLE_WINDOWS + 1);
    localparam int unsigned SW    = (SwRaw > 0) ? SwRaw : 1;

    typedef enum logic [1:0] {StIdle, StSettle, StRun} state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [PW-1:0]        r_prescaler;
    logic [DAC_WIDTH-1:0] r_sample_cnt;
    logic [DAC_WIDTH:0]   r_ones_acc;
    logic [SW-1:0]        r_settle_cnt;
    logic                 w_tick;
    logic                 w_win_end;
    logic [DAC_WIDTH:0]   w_total;
    logic                 w_full;

    assign w_tick    = (r_state != StIdle) && (r_prescaler == PW'(CLOCK_PRESCALER));
    assign w_win_end = w_tick && (r_sample_cnt == '1);
    // Count of ones in the window including the bit sampled on this tick.
    assign w_total   = r_ones_acc + (DAC_WIDTH + 1)'(r_sync2);
    assign w_full    = w_total[DAC_WIDTH];

    // Two-flop synchronizer for the asynchronous comparator output; free-running.
    always_ff @(posedge clock) begin
        r_sync1 <= sdm_in;
        r_sync2 <= r_sync1;
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; dropping enable returns to idle from any state.
    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = StIdle;
        end else begin
            case (r_state)
                StIdle:   w_state_next = StSettle;
                StSettle: begin
                    if (r_settle_cnt == SW'(SETTLE_WINDOWS)) begin
                        w_state_next = StRun;
                    end
                end
                StRun:    w_state_next = StRun;
                default:  w_state_next = StIdle;
            endcase
        end
    end

    // Prescaler, sample/ones/settle counters; cleared whenever idle or leaving.
    always_ff @(posedge clock) begin
        if (reset || !enable || (r_state == StIdle)) begin
            r_prescaler  <= '0;
            r_sample_cnt <= '0;
            r_ones_acc   <= '0;
            r_settle_cnt <= '0;
        end else begin
            r_prescaler <= w_tick ? '0 : r_prescaler + 1'b1;
            if (w_tick) begin
                r_sample_cnt <= r_sample_cnt + 1'b1;
                if (w_win_end) begin
                    r_ones_acc <= '0;
                    if (r_state == StSettle) begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end else begin
                    r_ones_acc <= w_total;
                end
            end
        end
    end

    // Outputs: feedback follows the tick bit, result published at RUN window ends.
    always_ff @(posedge clock) begin
        if (reset) begin
            sdm_fb        <= 1'b0;
            adc_value     <= '0;
            adc_valid     <= 1'b0;
            adc_overrange <= 1'b0;
        end else if (!enable || (r_state == StIdle)) begin
            // Leaving or sitting in idle wins over any coincident window end.
            sdm_fb    <= 1'b0;
            adc_valid <= 1'b0;
        end else begin
            adc_valid <= 1'b0;
            if (w_tick) begin
                sdm_fb <= r_sync2;
            end
            if (w_win_end && (r_state == StRun)) begin
                adc_value     <= w_full ? '1 : w_total[DAC_WIDTH-1:0];
                adc_overrange <= w_full;
                adc_valid     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sigma_delta_adc.sv
// Bench for sigma_delta_adc: two instances (SETTLE_WINDOWS=1 and 0) share stimulus;
// a schedule-based model predicts every output each cycle, plus directed literals.
module tb_sigma_delta_adc;

    localparam int P   = 1;
    localparam int W   = 4;
    localparam int WIN = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       sdm_in;
    logic       fb  [2];
    logic       vld [2];
    logic       ovr [2];
    logic [3:0] val [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int e0    = 0;

    sigma_delta_adc #(
        .CLOCK_PRESCALER(P), .DAC_WIDTH(W), .SETTLE_WINDOWS(1)
    ) u_dut0 (
        .clock(clock), .reset(reset), .enable(enable), .sdm_in(sdm_in),
        .sdm_fb(fb[0]), .adc_value(val[0]), .adc_valid(vld[0]), .adc_overrange(ovr[0])
    );

    sigma_delta_adc #(
        .CLOCK_PRESCALER(P), .DAC_WIDTH(W), .SETTLE_WINDOWS(0)
    ) u_dut1 (
        .clock(clock), .reset(reset), .enable(enable), .sdm_in(sdm_in),
        .sdm_fb(fb[1]), .adc_value(val[1]), .adc_valid(vld[1]), .adc_overrange(ovr[1])
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Edges counted from the enabling edge; ticks every P+1 edges; bit at an
    // edge is sdm_in as sampled two edges earlier.
    int         m_n    [2];
    bit         m_act  [2];
    int         m_ones [2];
    logic       m_fb   [2];
    logic [3:0] m_val  [2];
    logic       m_ovr  [2];
    logic       m_vld  [2];
    logic       h1 = 1'b0;
    logic       h2 = 1'b0;
    bit         started = 1'b0;

    always @(posedge clock) begin
        logic b;
        int   s;
        int   t;
        b  = h2;
        h2 = h1;
        h1 = sdm_in;
        for (int i = 0; i < 2; i++) begin
            s = (i == 0) ? 1 : 0;
            m_vld[i] = 1'b0;
            if (reset) begin
                m_act[i] = 1'b0;
                m_fb[i]  = 1'b0;
                m_val[i] = 4'd0;
                m_ovr[i] = 1'b0;
            end else if (!enable) begin
                m_act[i] = 1'b0;
                m_fb[i]  = 1'b0;
            end else if (!m_act[i]) begin
                m_act[i]  = 1'b1;
                m_n[i]    = 0;
                m_ones[i] = 0;
            end else begin
                m_n[i] = m_n[i] + 1;
                if (m_n[i] % (P + 1) == 0) begin
                    t         = m_n[i] / (P + 1);
                    m_fb[i]   = b;
                    m_ones[i] = m_ones[i] + int'(b);
                    if (t % WIN == 0) begin
                        if (t / WIN > s) begin
                            m_val[i] = (m_ones[i] > 15) ? 4'd15 : 4'(m_ones[i]);
                            m_ovr[i] = (m_ones[i] == WIN);
                            m_vld[i] = 1'b1;
                        end
                        m_ones[i] = 0;
                    end
                end
            end
        end
        started = 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                chk((i == 0) ? "model_valid0" : "model_valid1", 32'(vld[i]), 32'(m_vld[i]));
                chk((i == 0) ? "model_value0" : "model_value1", 32'(val[i]), 32'(m_val[i]));
                chk((i == 0) ? "model_ovr0" : "model_ovr1", 32'(ovr[i]), 32'(m_ovr[i]));
                chk((i == 0) ? "model_fb0" : "model_fb1", 32'(fb[i]), 32'(m_fb[i]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge: the next posedge becomes E0.
    task automatic start();
        enable = 1'b1;
        e0     = cyc + 1;
    endtask

    // Advance to the negedge following edge E0+n.
    task automatic to_rel(input int n);
        while (cyc < e0 + n) @(negedge clock);
    endtask

    task automatic stop();
        enable = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        sdm_in = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_value", 32'(val[0]), 0);
        chk("rst_valid", 32'(vld[0]), 0);
        chk("rst_ovr", 32'(ovr[0]), 0);
        chk("rst_fb", 32'(fb[0]), 0);
        reset = 1'b0;
        @(negedge clock);

        // 1: input held low
        start();
        sdm_in = 1'b0;
        to_rel(32);  chk("s1_d1_first_valid", 32'(vld[1]), 1);
        to_rel(63);  chk("s1_no_early_valid", 32'(vld[0]), 0);
        to_rel(64);  chk("s1_first_valid", 32'(vld[0]), 1);
                     chk("s1_value", 32'(val[0]), 0);
                     chk("s1_ovr", 32'(ovr[0]), 0);
                     chk("s1_fb", 32'(fb[0]), 0);
        to_rel(96);  chk("s1_second_valid", 32'(vld[0]), 1);
        to_rel(97);  chk("s1_valid_one_clock", 32'(vld[0]), 0);
        stop();

        // 3a: 11 ones per 16 ticks
        start();
        sdm_in = 1'b1;
        for (int m = 0; m < 98; m++) begin
            to_rel(m);
            if (m == 64) begin
                chk("s3a_valid", 32'(vld[0]), 1);
                chk("s3a_value", 32'(val[0]), 11);
                chk("s3a_ovr", 32'(ovr[0]), 0);
            end
            if (m == 96) chk("s3a_d1_value", 32'(val[1]), 11);
            sdm_in = (((m + 1) / 2) % 16) < 11;
        end
        stop();

        // 3b: ones only during the settle window
        start();
        sdm_in = 1'b1;
        for (int m = 0; m < 66; m++) begin
            to_rel(m);
            if (m < 64) chk("s3b_no_valid", 32'(vld[0]), 0);
            if (m == 63) chk("s3b_value_held", 32'(val[0]), 11);
            if (m == 64) begin
                chk("s3b_valid", 32'(vld[0]), 1);
                chk("s3b_value", 32'(val[0]), 0);
            end
            sdm_in = (m + 1) < 32;
        end
        stop();

        // 2: input held high
        start();
        sdm_in = 1'b1;
        to_rel(1);   chk("s2_fb_before_tick", 32'(fb[0]), 0);
        to_rel(2);   chk("s2_fb_first_tick", 32'(fb[0]), 1);
        to_rel(64);  chk("s2_valid", 32'(vld[0]), 1);
                     chk("s2_value", 32'(val[0]), 15);
                     chk("s2_ovr", 32'(ovr[0]), 1);
        to_rel(96);  chk("s2_value2", 32'(val[0]), 15);
                     chk("s2_ovr2", 32'(ovr[0]), 1);
        stop();

        // 4: enable dropped at E0+50, raised at E0+60
        start();
        sdm_in = 1'b1;
        to_rel(49);  chk("s4_fb_before_drop", 32'(fb[0]), 1);
        enable = 1'b0;
        to_rel(51);  chk("s4_fb_dropped", 32'(fb[0]), 0);
        to_rel(59);
        enable = 1'b1;
        sdm_in = 1'b0;
        for (int m = 60; m < 124; m++) begin
            to_rel(m);
            chk("s4_no_valid", 32'(vld[0]), 0);
            chk("s4_value_held", 32'(val[0]), 15);
        end
        to_rel(124); chk("s4_valid", 32'(vld[0]), 1);
                     chk("s4_value", 32'(val[0]), 0);
                     chk("s4_ovr", 32'(ovr[0]), 0);

        // 5: reset pulse mid-window in RUN (E0 rebased to the re-enable edge)
        e0 = e0 + 60;
        to_rel(69);
        sdm_in = 1'b1;
        reset  = 1'b1;
        to_rel(70);  chk("s5_value", 32'(val[0]), 0);
                     chk("s5_valid", 32'(vld[0]), 0);
                     chk("s5_ovr", 32'(ovr[0]), 0);
                     chk("s5_fb", 32'(fb[0]), 0);
        reset = 1'b0;
        e0 = e0 + 71;
        to_rel(63);  chk("s5_no_early_valid", 32'(vld[0]), 0);
        to_rel(64);  chk("s5_valid_after", 32'(vld[0]), 1);
                     chk("s5_value_after", 32'(val[0]), 15);
        stop();

        // 6: no settle windows, alternating bits per tick
        start();
        sdm_in = 1'b1;
        for (int m = 0; m < 98; m++) begin
            to_rel(m);
            if (m == 31) chk("s6_no_early_valid", 32'(vld[1]), 0);
            if (m == 32 || m == 64 || m == 96) begin
                chk("s6_valid", 32'(vld[1]), 1);
                chk("s6_value", 32'(val[1]), 8);
                chk("s6_ovr", 32'(ovr[1]), 0);
            end
            sdm_in = (((m + 1) / 2) % 2) == 0;
        end
        stop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
